// File: rtl/ks_adder_top.sv
// ks_adder_top
//   Registered Kogge-Stone parallel-prefix adder with carry-in. Operands are
//   captured in input registers. The sum is computed through a log2-depth
//   prefix carry tree and registered, so every timing path is register to register.
//
// Ports
//   clk  : rising-edge clock for all registers
//   rst  : asynchronous active-high reset, clears every register
//   A, B : DATA_WIDTH-bit unsigned operands
//   Cin  : carry-in
//   S    : OUTPUT_WIDTH-bit registered sum, S[DATA_WIDTH] is the carry-out
//
// Latency is two rising edges from an input change to S. Throughput is one
// operand set per cycle.
module ks_adder_top #(
  parameter int DATA_WIDTH   = 14,
  parameter int OUTPUT_WIDTH = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  input  logic                    Cin,
  output logic [OUTPUT_WIDTH-1:0] S
);

  localparam int NUM_STAGES = $clog2(DATA_WIDTH);

  if (OUTPUT_WIDTH != DATA_WIDTH + 1) begin : g_width_check
    $error("ks_adder_top: OUTPUT_WIDTH must equal DATA_WIDTH+1");
  end

  if (DATA_WIDTH < 2) begin : g_min_width_check
    $error("ks_adder_top: DATA_WIDTH must be at least 2");
  end

  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic                  cin_r;

  logic [DATA_WIDTH-1:0] g_pre_s;
  logic [DATA_WIDTH-1:0] p_pre_s;
  logic [DATA_WIDTH-1:0] g_lvl0_s;
  logic [DATA_WIDTH-1:0] p_lvl0_s;
  logic [DATA_WIDTH-1:0] g_final_s;
  logic [DATA_WIDTH-1:0] unused_p_final_s;
  logic [DATA_WIDTH-1:0] carry_s;
  logic [DATA_WIDTH:0]   sum_s;

  // Input operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= {DATA_WIDTH{1'b0}};
      b_r   <= {DATA_WIDTH{1'b0}};
      cin_r <= 1'b0;
    end else begin
      a_r   <= A;
      b_r   <= B;
      cin_r <= Cin;
    end
  end

  assign g_pre_s = a_r & b_r;
  assign p_pre_s = a_r ^ b_r;

  // Cin acts as a generate at position -1. Bit 0 therefore already spans
  // down to -1. Its group propagate is zero because position -1 never
  // propagates. Every later cell that inherits this span becomes a gray cell.
  assign g_lvl0_s = {g_pre_s[DATA_WIDTH-1:1], g_pre_s[0] | (p_pre_s[0] & cin_r)};
  assign p_lvl0_s = {p_pre_s[DATA_WIDTH-1:1], 1'b0};

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int DIST = 2 ** k;

    logic [DATA_WIDTH-1:0] g_in_s;
    logic [DATA_WIDTH-1:0] p_in_s;
    logic [DATA_WIDTH-1:0] g_out_s;
    logic [DATA_WIDTH-1:0] p_out_s;

    if (k == 0) begin : g_first
      assign g_in_s = g_lvl0_s;
      assign p_in_s = p_lvl0_s;
    end else begin : g_next
      assign g_in_s = g_stage[k-1].g_out_s;
      assign p_in_s = g_stage[k-1].p_out_s;
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_cell
      if (i >= 2 * DIST) begin : g_black
        assign g_out_s[i] = g_in_s[i] | (p_in_s[i] & g_in_s[i-DIST]);
        assign p_out_s[i] = p_in_s[i] & p_in_s[i-DIST];
      end else if (i >= DIST) begin : g_gray
        // The combined span now reaches position -1, so only generate matters.
        assign g_out_s[i] = g_in_s[i] | (p_in_s[i] & g_in_s[i-DIST]);
        assign p_out_s[i] = 1'b0;
      end else begin : g_buffer
        assign g_out_s[i] = g_in_s[i];
        assign p_out_s[i] = p_in_s[i];
      end
    end
  end

  assign g_final_s        = g_stage[NUM_STAGES-1].g_out_s;
  assign unused_p_final_s = g_stage[NUM_STAGES-1].p_out_s;

  // c_0 = Cin and c_{i+1} = G[i:-1]. The top group generate is the carry-out.
  if (DATA_WIDTH > 1) begin : g_carry
    assign carry_s = {g_final_s[DATA_WIDTH-2:0], cin_r};
  end else begin : g_carry_single
    assign carry_s = cin_r;
  end

  assign sum_s = {g_final_s[DATA_WIDTH-1], p_pre_s ^ carry_s};

  // Registered sum output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S <= {OUTPUT_WIDTH{1'b0}};
    end else begin
      S <= sum_s;
    end
  end

endmodule

// File: tb/tb_ks_adder_top.sv
// Testbench for ks_adder_top. Directed steps are followed by a random stream
// that is checked against a plain-arithmetic reference model.
module tb_ks_adder_top;

  localparam int DW = 14;
  localparam int OW = 15;

  logic          clk;
  logic          rst;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          Cin;
  logic [OW-1:0] S;

  int tests_run;
  int tests_failed;

  ks_adder_top #(.DATA_WIDTH(DW), .OUTPUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Cin (Cin),
    .S   (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the exact unsigned sum.
  function automatic logic [OW-1:0] ref_sum(input int a, input int b, input int c);
    int total;
    total = a + b + c;
    return total[OW-1:0];
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] expected);
    tests_run++;
    assert (S === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: S=%0d expected %0d", tag, S, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int c);
    @(negedge clk);
    A   = a[DW-1:0];
    B   = b[DW-1:0];
    Cin = c[0];
  endtask

  // Applies one operand set, waits two edges, and checks the result.
  task automatic apply_check(input string tag, input int a, input int b, input int c,
                             input logic [OW-1:0] expected);
    drive(a, b, c);
    tick();
    tick();
    check(tag, expected);
  endtask

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_v;
  int            ra;
  int            rb;
  int            rc;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0;
    A   = 14'd5;
    B   = 14'd20;
    Cin = 1'b1;

    // Reset is held while operands are present.
    #2 rst = 1'b1;
    #1 check("reset_async", 15'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", 15'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset_edge1", 15'd0);
    tick();
    check("post_reset_edge2", 15'd26);

    // All-zero operands for five cycles.
    drive(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 1) check("zeros", 15'd0);
    end

    apply_check("basic_5_20_1",      5,     20,    1, 15'd26);
    apply_check("basic_123_321_1",   123,   321,   1, 15'd445);
    apply_check("carry_chain",       16383, 0,     1, 15'd16384);
    apply_check("max_sum",           16383, 16383, 1, 15'd32767);
    apply_check("max_no_cin",        16383, 16383, 0, 15'd32766);
    apply_check("alt_bits",          10922, 5461,  1, 15'd16384);

    // Back-to-back streaming, one operand set per cycle.
    drive(1, 1, 0);
    tick();
    drive(8191, 8192, 1);
    tick();
    check("stream_0", 15'd2);
    drive(10922, 5461, 0);
    tick();
    check("stream_1", 15'd16384);
    tick();
    check("stream_2", 15'd16383);

    // Mid-stream reset pulse discards the in-flight operands.
    drive(100, 200, 0);
    tick();
    drive(300, 400, 1);
    tick();
    check("pre_pulse", 15'd300);
    #1 rst = 1'b1;
    #1 check("pulse_async", 15'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("pulse_lost", 15'd0);
    tick();
    check("pulse_recover", 15'd701);

    // Random stream against the reference model, two-edge lag.
    for (int i = 0; i < 10000; i++) begin
      ra = int'($urandom_range(0, 16383));
      rb = int'($urandom_range(0, 16383));
      rc = int'($urandom_range(0, 1));
      drive(ra, rb, rc);
      exp_q.push_back(ref_sum(ra, rb, rc));
      tick();
      if (exp_q.size() == 2) begin
        exp_v = exp_q.pop_front();
        check("random", exp_v);
      end
    end
    tick();
    exp_v = exp_q.pop_front();
    check("random_last", exp_v);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ks_adder_top.md
Name: ks_adder_top

Overview:
- Registered 14-bit Kogge-Stone parallel-prefix adder with carry-in.
- Captures operands A, B and Cin in input registers.
- Computes A+B+Cin through a log2-depth prefix carry tree and registers the 15-bit result (carry-out as MSB).
- Serves as the synthesis top for the adder datapath, giving register-to-register timing paths for STA.

Parameters:
- DATA_WIDTH, 14, operand width in bits; any value ≥ 2 must be supported.
- OUTPUT_WIDTH, 15, sum width; must equal DATA_WIDTH+1. Elaboration-time error if not.

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst  input  1  asynchronous, active-high reset; clears every register.
- A  input  DATA_WIDTH  operand A, unsigned.
- B  input  DATA_WIDTH  operand B, unsigned.
- Cin  input  1  carry-in.
- S  output  OUTPUT_WIDTH  registered sum. S[DATA_WIDTH-1:0] is the sum bits; S[DATA_WIDTH] is the carry-out.

Behaviour:
- Reset:
  - While rst=1, input registers (A_q, B_q, Cin_q) and output register S are 0 immediately, with no clock needed.
  - S=0 throughout reset.
  - Deassertion takes effect at the next rising clk edge.
- Pipeline, two stages, no handshake:
  - Edge n: A, B, Cin sampled into A_q, B_q, Cin_q.
  - Edge n+1: S <= A_q + B_q + Cin_q.
  - Latency is 2 rising edges from input change to S.
  - Throughput is one new operand set per cycle.
  - Inputs held constant give a constant S from the second edge onward.
- Arithmetic: unsigned, full-width, no overflow.
  - S = A + B + Cin exactly.
  - Maximum result is 2^(DATA_WIDTH+1)-1 (32767 for the default width).
- Prefix structure (mandatory, not a ripple or behavioural "+"):
  - Bitwise pre-processing: g_i = a_i & b_i, p_i = a_i ^ b_i.
  - Cin is folded in as a generate term at position -1: bit 0 group generate G0 = g_0 | (p_0 & Cin).
  - Prefix stages: ceil(log2(DATA_WIDTH)) stages, i.e. 4 for width 14. Stage k uses distance d = 2^k.
  - Black cell (positions i ≥ d): G = G_i | (P_i & G_{i-d}), P = P_i & P_{i-d}.
  - Buffer: positions i < d pass through unchanged.
  - Only generate is needed where the prefix has reached position -1 (gray cell).
  - Carries: c_0 = Cin, c_{i+1} = final G[i:0].
  - Sum: s_i = p_i ^ c_i; S[DATA_WIDTH] = c_DATA_WIDTH.
  - Build the tree with generate loops so any DATA_WIDTH elaborates.
- No X-propagation requirement beyond reset; an undriven rst is treated by simulation semantics only.
- Reset mid-operation: asserting rst while operands are in flight discards them; S=0 immediately.
  - After release, the first valid S appears two edges after the first post-reset sample.
- Simultaneous input change and reset: reset wins; nothing is captured while rst=1.

Test Plan:
- Reset: rst=1 with A=5, B=20, Cin=1 -> S=0 throughout; release and hold inputs -> S=26 two edges later.
- A=0, B=0, Cin=0 for 5 cycles -> S=0.
- A=5, B=20, Cin=1 -> S=26 exactly two edges after capture; A=123, B=321, Cin=1 -> S=445.
- Full carry chain: A=16383, B=0, Cin=1 -> S=16384, exercising every prefix level. A=16383, B=16383, Cin=1 -> S=32767 (carry-out=1).
- Back-to-back streaming:
  - Stimulus: new operands every cycle — (1,1,0), (8191,8192,1), (10922,5461,0).
  - Expected S sequence, one per cycle with 2-cycle lag: 2, 16384, 16383.
- Mid-stream reset: pulse rst for half a cycle between operand sets -> S drops to 0 asynchronously, and the in-flight result is lost. Recovery occurs with 2-cycle latency; then run 10k random A, B, Cin values against a reference model.
